// File: rtl/instr_fetch_stage.sv
// RV32I instruction fetch stage: owns the PC,
// drives the ROM address and fills IF/ID.
module instr_fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_WORDS = 256,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_pc_plus4,
  output logic [31:0] if_id_instr,
  output logic        if_id_valid,
  output logic [31:0] fetch_count,
  output logic [31:0] bubble_count
);

  localparam logic [31:0] WORDS = 32'(IMEM_WORDS);

  logic [31:0] pc_q, pc_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic [31:0] id_p4_q, id_p4_d;
  logic [31:0] id_ins_q, id_ins_d;
  logic        id_vld_q, id_vld_d;
  logic [31:0] fcnt_q, fcnt_d;
  logic [31:0] bcnt_q, bcnt_d;

  logic [31:0] pc_plus4;
  logic [31:0] word_idx;
  logic        in_range;
  logic [31:0] fetched;

  function automatic logic [31:0] sat_inc(
    input logic [31:0] v
  );
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  assign pc_plus4 = pc_q + 32'd4;
  assign word_idx = {2'b00, pc_q[31:2]};
  assign in_range = (word_idx < WORDS);
  assign fetched  = in_range ? imem_data : NOP_INSTR;

  // Next-state: redirect flushes, stall holds, else advance
  always_comb begin
    pc_d     = pc_q;
    id_pc_d  = id_pc_q;
    id_p4_d  = id_p4_q;
    id_ins_d = id_ins_q;
    id_vld_d = id_vld_q;
    fcnt_d   = fcnt_q;
    bcnt_d   = bcnt_q;
    if (redirect) begin
      pc_d     = redirect_pc & 32'hFFFF_FFFC;
      id_pc_d  = pc_q;
      id_p4_d  = pc_plus4;
      id_ins_d = NOP_INSTR;
      id_vld_d = 1'b0;
      bcnt_d   = sat_inc(bcnt_q);
    end else if (!stall) begin
      pc_d     = pc_plus4;
      id_pc_d  = pc_q;
      id_p4_d  = pc_plus4;
      id_ins_d = fetched;
      id_vld_d = in_range;
      if (in_range) fcnt_d = sat_inc(fcnt_q);
      else          bcnt_d = sat_inc(bcnt_q);
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q     <= RESET_PC;
      id_pc_q  <= 32'd0;
      id_p4_q  <= 32'd0;
      id_ins_q <= NOP_INSTR;
      id_vld_q <= 1'b0;
      fcnt_q   <= 32'd0;
      bcnt_q   <= 32'd0;
    end else begin
      pc_q     <= pc_d;
      id_pc_q  <= id_pc_d;
      id_p4_q  <= id_p4_d;
      id_ins_q <= id_ins_d;
      id_vld_q <= id_vld_d;
      fcnt_q   <= fcnt_d;
      bcnt_q   <= bcnt_d;
    end
  end

  assign imem_addr      = pc_q;
  assign if_id_pc       = id_pc_q;
  assign if_id_pc_plus4 = id_p4_q;
  assign if_id_instr    = id_ins_q;
  assign if_id_valid    = id_vld_q;
  assign fetch_count    = fcnt_q;
  assign bubble_count   = bcnt_q;

endmodule
